// File: rtl/mux_sel_reg_pkg.sv
// Shared types and helpers for the registered N:1 channel multiplexer.
// Flat buses up to BUS_MAX bits and words up to WORD_MAX bits are supported by chan_slice.
package mux_pkg;

    typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

    localparam int unsigned BUS_MAX  = 1024;
    localparam int unsigned WORD_MAX = 256;

    // Elaboration-time ceil(log2(n)), never less than 1 so a vector always exists.
    function automatic int unsigned bits_for(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++)
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic logic [WORD_MAX-1:0] chan_slice(input logic [BUS_MAX-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned w);
        return WORD_MAX'(bus >> (idx * w));
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Scan pointer and dwell counter; tick marks the enabled cycle that ends a dwell.
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 1,
    localparam int unsigned SEL_W   = bits_for(CHANNELS),
    localparam int unsigned DCNT_W  = bits_for(DWELL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             adv,
    output logic [SEL_W-1:0] ptr,
    output logic             tick
);

    logic [DCNT_W-1:0] dcnt;

    assign tick = adv && (dcnt == DCNT_W'(DWELL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr  <= '0;
            dcnt <= '0;
        end else if (load) begin
            ptr  <= load_val;
            dcnt <= '0;
        end else if (adv) begin
            if (tick) begin
                dcnt <= '0;
                ptr  <= (ptr == SEL_W'(CHANNELS - 1)) ? '0 : ptr + SEL_W'(1);
            end else begin
                dcnt <= dcnt + DCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mux_sel_reg.sv
// Registered N:1 multiplexer with manual select or rotating scan select.
module mux_sel_reg
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 1,
    localparam int unsigned SEL_W   = bits_for(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          dout_ch,
    output logic                      dout_vld
);

    localparam logic [SEL_W:0] N_CH = (SEL_W + 1)'(CHANNELS);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] cap_idx;
    logic [SEL_W-1:0] load_val;
    logic [WIDTH-1:0] cap_word;
    logic             sel_ok;
    logic             load;
    logic             adv;
    logic             tick;

    // mode=0 always means a manual capture, even on the clock leaving SCAN.
    assign sel_ok   = ({1'b0, sel} < N_CH);
    assign load     = (state == MANUAL) && mode;
    assign load_val = sel_ok ? sel : '0;
    assign adv      = (state == SCAN) && mode && en;
    assign cap_idx  = mode ? ptr : sel;
    assign cap_word = WIDTH'(chan_slice(BUS_MAX'(din), 32'(cap_idx), WIDTH));

    mux_scan_ctr #(
        .CHANNELS (CHANNELS),
        .DWELL    (DWELL)
    ) u_scan_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .adv      (adv),
        .ptr      (ptr),
        .tick     (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MANUAL;
        else     state <= mode ? SCAN : MANUAL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            dout_ch  <= '0;
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= 1'b0;
            if (!mode) begin
                if (en && sel_ok) begin
                    dout     <= cap_word;
                    dout_ch  <= cap_idx;
                    dout_vld <= 1'b1;
                end
            end else if (tick) begin
                dout     <= cap_word;
                dout_ch  <= cap_idx;
                dout_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_reg.sv
// Directed bench for mux_sel_reg: 4-channel, 3-channel and DWELL=3 instances.
module tb_mux_sel_reg;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] din_a;
    logic [1:0]  sel_a;
    logic        mode_a, en_a;
    logic [7:0]  dout_a;
    logic [1:0]  ch_a;
    logic        vld_a;

    logic [23:0] din_b;
    logic [1:0]  sel_b;
    logic        mode_b, en_b;
    logic [7:0]  dout_b;
    logic [1:0]  ch_b;
    logic        vld_b;

    logic [31:0] din_c;
    logic [1:0]  sel_c;
    logic        mode_c, en_c;
    logic [7:0]  dout_c;
    logic [1:0]  ch_c;
    logic        vld_c;

    mux_sel_reg #(.WIDTH(8), .CHANNELS(4), .DWELL(1)) u_a (
        .clk(clk), .rst(rst), .din(din_a), .sel(sel_a), .mode(mode_a), .en(en_a),
        .dout(dout_a), .dout_ch(ch_a), .dout_vld(vld_a)
    );

    mux_sel_reg #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) u_b (
        .clk(clk), .rst(rst), .din(din_b), .sel(sel_b), .mode(mode_b), .en(en_b),
        .dout(dout_b), .dout_ch(ch_b), .dout_vld(vld_b)
    );

    mux_sel_reg #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) u_c (
        .clk(clk), .rst(rst), .din(din_c), .sel(sel_c), .mode(mode_c), .en(en_c),
        .dout(dout_c), .dout_ch(ch_c), .dout_vld(vld_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] d, input logic [1:0] c, input logic v);
        chk({tag, ".dout"}, 32'(dout_a), 32'(d));
        chk({tag, ".ch"},   32'(ch_a),   32'(c));
        chk({tag, ".vld"},  32'(vld_a),  32'(v));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        din_a = 32'h44332211; sel_a = 2'd0; mode_a = 1'b0; en_a = 1'b0;
        din_b = 24'h7C6B5A;   sel_b = 2'd0; mode_b = 1'b0; en_b = 1'b0;
        din_c = 32'hC3C2C1C0; sel_c = 2'd0; mode_c = 1'b0; en_c = 1'b0;
        #2;
        chk_a("rst_init", 8'h00, 2'd0, 1'b0);
        chk("rst_init_c.vld", 32'(vld_c), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Manual select and hold
        sel_a = 2'd2; en_a = 1'b1;
        cyc();
        chk_a("man_sel2", 8'h33, 2'd2, 1'b1);
        en_a = 1'b0;
        cyc();
        chk_a("man_hold", 8'h33, 2'd2, 1'b0);

        // Out-of-range select on the 3-channel instance
        sel_b = 2'd2; en_b = 1'b1;
        cyc();
        chk("oor_pre.dout", 32'(dout_b), 32'h7C);
        chk("oor_pre.vld",  32'(vld_b),  32'd1);
        sel_b = 2'd3;
        cyc();
        chk("oor.dout", 32'(dout_b), 32'h7C);
        chk("oor.ch",   32'(ch_b),   32'd2);
        chk("oor.vld",  32'(vld_b),  32'd0);

        // Entering scan with out-of-range sel starts at channel 0
        mode_b = 1'b1;
        cyc();
        chk("b_scan_entry.vld", 32'(vld_b), 32'd0);
        cyc();
        chk("b_scan0.dout", 32'(dout_b), 32'h5A);
        chk("b_scan0.ch",   32'(ch_b),   32'd0);
        mode_b = 1'b0; en_b = 1'b0;

        // Scan with wrap from sel=1, DWELL=1
        mode_a = 1'b1; sel_a = 2'd1; en_a = 1'b1;
        cyc();
        chk_a("scan_entry", 8'h33, 2'd2, 1'b0);
        cyc();
        chk_a("scan_1", 8'h22, 2'd1, 1'b1);
        cyc();
        chk_a("scan_2", 8'h33, 2'd2, 1'b1);
        cyc();
        chk_a("scan_3", 8'h44, 2'd3, 1'b1);
        cyc();
        chk_a("scan_wrap0", 8'h11, 2'd0, 1'b1);
        cyc();
        chk_a("scan_1b", 8'h22, 2'd1, 1'b1);

        // Leave scan: immediate manual capture
        mode_a = 1'b0; sel_a = 2'd0;
        cyc();
        chk_a("exit_man0", 8'h11, 2'd0, 1'b1);
        // Re-enter: pointer reloads from sel
        mode_a = 1'b1; sel_a = 2'd3;
        cyc();
        chk_a("reenter", 8'h11, 2'd0, 1'b0);
        cyc();
        chk_a("reenter_cap", 8'h44, 2'd3, 1'b1);

        // Mode toggling every cycle yields only manual captures
        mode_a = 1'b0; sel_a = 2'd1;
        cyc();
        chk_a("tog_m0", 8'h22, 2'd1, 1'b1);
        mode_a = 1'b1;
        cyc();
        chk_a("tog_s", 8'h22, 2'd1, 1'b0);
        mode_a = 1'b0; sel_a = 2'd2;
        cyc();
        chk_a("tog_m1", 8'h33, 2'd2, 1'b1);
        en_a = 1'b0;

        // DWELL=3 with an enable gap
        mode_c = 1'b1; sel_c = 2'd0; en_c = 1'b1;
        cyc();
        chk("dw_entry.vld", 32'(vld_c), 32'd0);
        cyc();
        chk("dw_e1.vld", 32'(vld_c), 32'd0);
        cyc();
        chk("dw_e2.vld", 32'(vld_c), 32'd0);
        en_c = 1'b0;
        cyc();
        chk("dw_gap.vld", 32'(vld_c), 32'd0);
        en_c = 1'b1;
        cyc();
        chk("dw_e3.vld",  32'(vld_c),  32'd1);
        chk("dw_e3.dout", 32'(dout_c), 32'hC0);
        chk("dw_e3.ch",   32'(ch_c),   32'd0);
        cyc();
        chk("dw_e4.vld", 32'(vld_c), 32'd0);
        cyc();
        chk("dw_e5.vld", 32'(vld_c), 32'd0);
        cyc();
        chk("dw_e6.vld",  32'(vld_c),  32'd1);
        chk("dw_e6.dout", 32'(dout_c), 32'hC1);
        chk("dw_e6.ch",   32'(ch_c),   32'd1);
        en_c = 1'b0;

        // Asynchronous reset mid-operation
        din_a = 32'h4433A511; mode_a = 1'b0; sel_a = 2'd1; en_a = 1'b1;
        cyc();
        chk_a("pre_rst", 8'hA5, 2'd1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_a("async_rst", 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mode_a = 1'b0; sel_a = 2'd3; en_a = 1'b1;
        cyc();
        chk_a("post_rst_man", 8'h44, 2'd3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_reg.md
# mux_sel_reg

Parametrised, registered N:1 multiplexer that generalises the team's 2:1 combinational mux used ahead of the D flip-flop stages. It selects one of CHANNELS words of WIDTH bits and registers the result. The select comes either from the external `sel` port (manual mode) or from an internal scan pointer that rotates through all channels with a programmable dwell (scan mode). It sits in the datapath wherever a captured, channel-tagged sample from a bank of sources is needed.

## Interface
- WIDTH, 8, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- DWELL, 1, enabled cycles spent per channel in scan mode (≥1)
- SEL_W, $clog2(CHANNELS), select/pointer width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  CHANNELS*WIDTH  flattened inputs; channel k = din[k*WIDTH +: WIDTH]
- sel  in  SEL_W  manual channel select
- mode  in  1  0 = manual, 1 = scan
- en  in  1  capture enable
- dout  out  WIDTH  registered selected word
- dout_ch  out  SEL_W  channel index of `dout`
- dout_vld  out  1  one-cycle strobe: `dout` updated this cycle

## Operation
- FSM states: MANUAL, SCAN. The state register follows `mode` each clock.
  - MANUAL→SCAN when mode=1.
  - SCAN→MANUAL when mode=0.
- MANUAL, en=1, sel<CHANNELS: dout←din[sel], dout_ch←sel, dout_vld←1.
- MANUAL, en=1, sel≥CHANNELS (out-of-range, only possible when CHANNELS is not a power of 2): dout and dout_ch hold, dout_vld←0.
- SCAN behaviour:
  - Scan pointer `ptr` and dwell counter `dcnt` (width $clog2(DWELL+1)) advance only on en=1.
  - On an en=1 cycle with dcnt==DWELL-1: dout←din[ptr], dout_ch←ptr, dout_vld←1, dcnt←0, ptr←(ptr==CHANNELS-1)?0:ptr+1.
  - On en=1 with dcnt<DWELL-1: dcnt←dcnt+1, dout_vld←0.
- On the MANUAL→SCAN transition clock: ptr←(sel<CHANNELS)?sel:0, dcnt←0. No capture occurs on that clock and dout_vld←0.
- On the SCAN→MANUAL transition clock: the manual rule applies immediately, so a capture occurs if en=1. ptr and dcnt are frozen.
- en=0 in either state: all data registers hold, dout_vld←0.
- The `mode` input is sampled each clock. `mode` toggling every cycle is legal and only ever produces manual captures.

## Timing
- Reset (async assert, sync release by environment): dout=0, dout_ch=0, dout_vld=0, state=MANUAL, ptr=0, dcnt=0.
- Reset mid-scan aborts immediately. The first post-reset clock behaves as MANUAL.
- Latency in MANUAL: 1 clock from din/sel/en sampled to dout/dout_vld.
- Throughput in SCAN: one dout_vld per DWELL enabled cycles. With DWELL=1 and en held high, dout_vld is continuously 1 and dout_ch runs 0,1,…,CHANNELS-1,0.
- Pointer wrap: after channel CHANNELS-1 the next capture is channel 0. There is no idle cycle at the wrap.
- `din` is sampled at the capture edge only. No input registering and no combinational path from input to output.

## Structure
- Package `mux_pkg`:
  - state enum {MANUAL, SCAN}
  - constant function for SEL_W / dcnt width
  - helper function that slices a channel from the flat bus
- Sub-module `mux_scan_ctr`: ptr and dcnt registers. Inputs are load (with load value), advance-enable and DWELL/CHANNELS parameters. Outputs are ptr and a `tick` (dcnt==DWELL-1 && en).
- Top level contains the FSM, the output registers and the channel select.

## Test plan
- Reset: assert rst mid-operation with dout=8'hA5 → dout=0, dout_ch=0, dout_vld=0 asynchronously. After release, state is MANUAL.
- Manual select: WIDTH=8, CHANNELS=4, din={8'h44,8'h33,8'h22,8'h11}, en=1, sel=2 → next clock dout=8'h33, dout_ch=2, dout_vld=1. Then en=0 → dout holds 8'h33, dout_vld=0.
- Out-of-range: CHANNELS=3, sel=3, en=1 → dout and dout_ch unchanged, dout_vld=0.
- Scan with wrap: DWELL=1, mode=1 with sel=1, en=1 for 6 clocks → first clock dout_vld=0. Then captured dout_ch sequence is 1,2,3,0,1 with matching din words.
- Dwell and enable gaps: DWELL=3, scan mode, en pattern 1,1,0,1,1,1,1 → dout_vld asserted only after the 3rd and 6th enabled cycles. The en=0 cycle holds dcnt.
- Mode switch back: in SCAN at ptr=2, set mode=0, sel=0, en=1 → the same clock captures din[0] with dout_ch=0. Re-entering SCAN reloads ptr from sel.
